inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
- Instruction fetch stage directly upstream of the HV instruction decoder.
- Holds the program in a local register-file instruction memory that the host loads before a run.
- On start, steps a program counter from 0 to a programmed end address, repeating the whole program a programmed number of times.
- Presents one instruction per cycle with a valid flag; the flag drives the decoder enable. Fetch stalls when the datapath (IM FIFOs, AM) cannot accept an instruction.

Parameters:
- InstWidth, 32, instruction word width; matches decoder.
- InstDepth, 256, instruction memory entries.
- LoopWidth, 16, width of the program repeat counter.
- InstAddrWidth, $clog2(InstDepth), derived; do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active-low.
- inst_wr_en_i  in  1  host write strobe into instruction memory.
- inst_wr_addr_i  in  InstAddrWidth  host write address.
- inst_wr_data_i  in  InstWidth  host write data.
- start_i  in  1  start-run pulse.
- clr_i  in  1  synchronous abort/clear.
- end_addr_i  in  InstAddrWidth  last PC of the program.
- loop_cnt_i  in  LoopWidth  number of program iterations; 0 is treated as 1.
- stall_i  in  1  datapath not ready; hold the current instruction.
- inst_code_o  out  InstWidth  instruction to the decoder.
- inst_valid_o  out  1  instruction valid; connects to decoder enable_i.
- inst_pc_o  out  InstAddrWidth  current PC.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle pulse at run completion.

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE; pc=0; iter=0; latched end_addr=0, loop_cnt=0.
- Reset output values: inst_code_o=0, inst_valid_o=0, busy_o=0, done_o=0, inst_pc_o=0.
- Memory contents are not reset.
- Memory write: a write commits at the clock edge only when state==IDLE and inst_wr_en_i=1. Writes in RUN or DONE are dropped.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 latches end_addr_i and max(loop_cnt_i,1).
  - Sets pc=0, iter=0, and moves to RUN on the next cycle.
  - A write and a start in the same cycle are both honoured; the first fetch sees the new data.
- RUN:
  - busy_o=1.
  - inst_valid_o = !stall_i.
  - inst_code_o = mem[pc] when valid, else 0.
  - Combinational read, zero latency from pc to inst_code_o.
- Advance happens when inst_valid_o=1:
  - pc<end_addr: pc++.
  - pc==end_addr and iter<loop_cnt-1: pc=0, iter++.
  - pc==end_addr and iter==loop_cnt-1: move to DONE; pc holds.
- Stall: pc, iter and state hold. No instruction is dropped or duplicated.
- start_i during RUN or DONE is ignored.
- end_addr_i and loop_cnt_i changes during a run have no effect (values are latched).
- DONE: done_o=1 for exactly one cycle, busy_o=0, inst_valid_o=0, then IDLE.
- clr_i=1 in any state: next cycle is IDLE with pc=0, iter=0. There is no done_o pulse, and the instruction on the clr_i cycle is still presented. clr_i has priority over start_i.
- Latency (no stalls, start at cycle t):
  - Valid instructions cover cycles t+1 .. t+(E+1)*L.
  - done_o at cycle t+(E+1)*L+1, where E is end_addr and L the effective loop count.
- end_addr=0: a single-instruction program, valid for L cycles.
- pc is InstAddrWidth wide and never exceeds end_addr, so it never wraps.
- iter is LoopWidth wide; a maximum loop_cnt completes without overflow.
- Reset asserted mid-run: immediate IDLE and all outputs to reset values.

Test Plan:
- Load mem[0..3]=0xA0..0xA3, end=3, loop=1, start, stall=0 -> inst_code_o A0,A1,A2,A3 in cycles t+1..t+4; done_o=1 only at t+5; busy_o high t+1..t+4.
- Same program with loop=3 -> 12 valid cycles with PC sequence 0,1,2,3 repeated 3 times; done_o at t+13. Repeat with loop=0 -> behaves as loop=1.
- stall_i high for 2 cycles while pc=2 -> inst_valid_o=0 and inst_code_o=0 for those cycles; pc holds at 2; A2 is then issued exactly once; done_o is delayed by 2 cycles.
- Write mem[1]=0xFF during RUN -> ignored; the next run still fetches the old mem[1]. Write plus start in the same IDLE cycle to addr 0 -> first fetched code is the new data.
- clr_i at pc=2 of loop 1 of 3 -> next cycle busy_o=0, pc=0, no done_o. clr_i and start_i together in IDLE -> stays IDLE.
- rst_ni low mid-run for 1 cycle -> all outputs 0 asynchronously. A new start after reset runs cleanly from pc=0, and memory contents are retained.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch stage: local program memory, PC/iteration sequencing,
// stall-aware instruction issue to the HV instruction decoder.
module inst_fetch_ctrl #(
    parameter int InstWidth     = 32,
    parameter int InstDepth     = 256,
    parameter int LoopWidth     = 16,
    parameter int InstAddrWidth = $clog2(InstDepth)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     inst_wr_en_i,
    input  logic [InstAddrWidth-1:0] inst_wr_addr_i,
    input  logic [InstWidth-1:0]     inst_wr_data_i,
    input  logic                     start_i,
    input  logic                     clr_i,
    input  logic [InstAddrWidth-1:0] end_addr_i,
    input  logic [LoopWidth-1:0]     loop_cnt_i,
    input  logic                     stall_i,
    output logic [InstWidth-1:0]     inst_code_o,
    output logic                     inst_valid_o,
    output logic [InstAddrWidth-1:0] inst_pc_o,
    output logic                     busy_o,
    output logic                     done_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [InstAddrWidth-1:0] pc_q, pc_d;
    logic [InstAddrWidth-1:0] end_q, end_d;
    logic [LoopWidth-1:0]     iter_q, iter_d;
    logic [LoopWidth-1:0]     loop_q, loop_d;
    logic                     fire;

    logic [InstWidth-1:0] mem [InstDepth];

    // Host may only rewrite the program while no run is in flight.
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && inst_wr_en_i) begin
            mem[inst_wr_addr_i] <= inst_wr_data_i;
        end
    end

    assign fire         = (state_q == RUN) && !stall_i;
    assign inst_valid_o = fire;
    assign inst_code_o  = fire ? mem[pc_q] : '0;
    assign inst_pc_o    = pc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pc_q    <= '0;
            iter_q  <= '0;
            end_q   <= '0;
            loop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            iter_q  <= iter_d;
            end_q   <= end_d;
            loop_q  <= loop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        iter_d  = iter_q;
        end_d   = end_q;
        loop_d  = loop_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    end_d   = end_addr_i;
                    loop_d  = (loop_cnt_i == '0) ? LoopWidth'(1) : loop_cnt_i;
                    pc_d    = '0;
                    iter_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (fire) begin
                    // pc never passes end_q, so inequality means "below end".
                    if (pc_q != end_q) begin
                        pc_d = pc_q + 1'b1;
                    end else if (iter_q != loop_q - 1'b1) begin
                        pc_d   = '0;
                        iter_d = iter_q + 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
                pc_d    = '0;
                iter_d  = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (clr_i) begin
            state_d = IDLE;
            pc_d    = '0;
            iter_d  = '0;
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios plus random
// traffic, compared against a queue-based model of the expected fetch stream.
module tb_inst_fetch_ctrl;

    localparam int IW = 32;
    localparam int ID = 256;
    localparam int LW = 16;
    localparam int AW = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          inst_wr_en_i = 1'b0;
    logic [AW-1:0] inst_wr_addr_i = '0;
    logic [IW-1:0] inst_wr_data_i = '0;
    logic          start_i = 1'b0;
    logic          clr_i = 1'b0;
    logic [AW-1:0] end_addr_i = '0;
    logic [LW-1:0] loop_cnt_i = '0;
    logic          stall_i = 1'b0;
    logic [IW-1:0] inst_code_o;
    logic          inst_valid_o;
    logic [AW-1:0] inst_pc_o;
    logic          busy_o;
    logic          done_o;

    inst_fetch_ctrl #(
        .InstWidth(IW),
        .InstDepth(ID),
        .LoopWidth(LW)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .inst_wr_en_i   (inst_wr_en_i),
        .inst_wr_addr_i (inst_wr_addr_i),
        .inst_wr_data_i (inst_wr_data_i),
        .start_i        (start_i),
        .clr_i          (clr_i),
        .end_addr_i     (end_addr_i),
        .loop_cnt_i     (loop_cnt_i),
        .stall_i        (stall_i),
        .inst_code_o    (inst_code_o),
        .inst_valid_o   (inst_valid_o),
        .inst_pc_o      (inst_pc_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: program memory image, and the list of PCs still to
    // be issued in the current run (one entry per instruction to deliver).
    logic [IW-1:0] mm [ID];
    int            pend[$];
    bit            done_pend = 0;
    int            last_pc = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        inst_wr_en_i = 1'b0;
        start_i      = 1'b0;
        clr_i        = 1'b0;
        stall_i      = 1'b0;
    endtask

    // One clock: check outputs at negedge, then advance the model at posedge.
    task automatic step();
        logic [IW-1:0] ec;
        logic          ev, eb, ed;
        int            ep;
        int            l_eff;
        bit            idle;
        @(negedge clk_i);
        if (pend.size() > 0) begin
            ev = !stall_i;
            ep = pend[0];
            ec = ev ? mm[pend[0]] : '0;
            eb = 1'b1;
            ed = 1'b0;
        end else if (done_pend) begin
            ev = 1'b0; ec = '0; eb = 1'b0; ed = 1'b1; ep = last_pc;
        end else begin
            ev = 1'b0; ec = '0; eb = 1'b0; ed = 1'b0; ep = 0;
        end
        check("valid", 64'(inst_valid_o), 64'(ev));
        check("code", 64'(inst_code_o), 64'(ec));
        check("pc", 64'(inst_pc_o), 64'(ep));
        check("busy", 64'(busy_o), 64'(eb));
        check("done", 64'(done_o), 64'(ed));
        @(posedge clk_i);
        idle = (pend.size() == 0) && !done_pend;
        if (idle && inst_wr_en_i) mm[inst_wr_addr_i] = inst_wr_data_i;
        if (clr_i) begin
            pend.delete();
            done_pend = 0;
        end else if (pend.size() > 0) begin
            if (!stall_i) begin
                last_pc = pend.pop_front();
                if (pend.size() == 0) done_pend = 1;
            end
        end else if (done_pend) begin
            done_pend = 0;
        end else if (start_i) begin
            l_eff = (loop_cnt_i == 0) ? 1 : int'(loop_cnt_i);
            for (int l = 0; l < l_eff; l++)
                for (int p = 0; p <= int'(end_addr_i); p++)
                    pend.push_back(p);
        end
        #1;
    endtask

    task automatic wr(input int a, input logic [IW-1:0] d);
        inst_wr_en_i   = 1'b1;
        inst_wr_addr_i = AW'(a);
        inst_wr_data_i = d;
        step();
        inst_wr_en_i = 1'b0;
    endtask

    task automatic start(input int e, input int l);
        start_i    = 1'b1;
        end_addr_i = AW'(e);
        loop_cnt_i = LW'(l);
        step();
        start_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((pend.size() > 0 || done_pend) && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", 64'(pend.size() > 0 || done_pend), 64'(0));
        step();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #2;
        check("rst_valid", 64'(inst_valid_o), 64'(0));
        check("rst_code", 64'(inst_code_o), 64'(0));
        check("rst_pc", 64'(inst_pc_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_done", 64'(done_o), 64'(0));
        pend.delete();
        done_pend = 0;
        @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        #1;
    endtask

    initial begin
        idle_inputs();
        #3;
        do_reset();
        step();
        for (int a = 0; a < ID; a++) wr(a, IW'($urandom));
        for (int a = 0; a < 4; a++) wr(a, IW'(32'hA0 + a));

        // Basic runs: loop 1, 3, and 0 (treated as 1).
        start(3, 1); drain(50);
        start(3, 3); drain(50);
        start(3, 0); drain(50);
        start(0, 4); drain(50);

        // Two stall cycles while pc=2.
        start(3, 1);
        step(); step();
        stall_i = 1'b1; step(); step();
        stall_i = 1'b0; drain(50);

        // Write during run is dropped; next run still sees old mem[1].
        start(3, 1);
        inst_wr_en_i = 1'b1; inst_wr_addr_i = 8'd1; inst_wr_data_i = 32'hFF;
        step(); step();
        inst_wr_en_i = 1'b0;
        drain(50);
        start(3, 1); drain(50);

        // Write and start in the same cycle: first fetch sees new data.
        inst_wr_en_i = 1'b1; inst_wr_addr_i = 8'd0; inst_wr_data_i = 32'h5A5A;
        start(3, 1);
        inst_wr_en_i = 1'b0;
        drain(50);

        // Clear at pc=2 of the second iteration of three.
        start(3, 3);
        for (int i = 0; i < 6; i++) step();
        clr_i = 1'b1; step();
        clr_i = 1'b0; step(); step();
        // Clear and start together in IDLE: stays idle.
        clr_i = 1'b1; start(3, 1);
        clr_i = 1'b0; step(); step();

        // Reset mid-run, then a clean run on retained memory.
        start(3, 2);
        step(); step(); step();
        do_reset();
        step();
        start(3, 1); drain(50);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            start_i        = ($urandom_range(0, 9) == 0);
            clr_i          = ($urandom_range(0, 49) == 0);
            stall_i        = ($urandom_range(0, 9) < 3);
            inst_wr_en_i   = ($urandom_range(0, 4) == 0);
            inst_wr_addr_i = AW'($urandom_range(0, 15));
            inst_wr_data_i = IW'($urandom);
            end_addr_i     = AW'($urandom_range(0, 15));
            loop_cnt_i     = LW'($urandom_range(0, 3));
            step();
        end
        idle_inputs();
        drain(500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
